grf_wb_arbiter: RTL

//  Shares the single GRF write port (RegWrite/RD/WData) between two writeback

---
 rtl/grf_wb_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: shares the single GRF write port between the datapath
// writeback (WB0) and the link-register writeback (WB1). Each requester owns a
// one-entry holding buffer. A single registered grant per cycle drives
// RegWrite/RD/WData, and writes to $0 are dropped at the handshake.
// Optional feature: define GRF_WB_BYPASS_EN to add the read-stage bypass ports
// (Byp_Addr, Byp_Hit, Byp_Data).
module grf_wb_arbiter #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int ARB_RR = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          WB0_Valid,
  output logic          WB0_Ready,
  input  logic [AW-1:0] WB0_Addr,
  input  logic [DW-1:0] WB0_Data,
  input  logic          WB1_Valid,
  output logic          WB1_Ready,
  input  logic [AW-1:0] WB1_Addr,
  input  logic [DW-1:0] WB1_Data,
  output logic          RegWrite,
  output logic [AW-1:0] RD,
  output logic [DW-1:0] WData,
  output logic          Busy
`ifdef GRF_WB_BYPASS_EN
  ,
  input  logic [AW-1:0] Byp_Addr,
  output logic          Byp_Hit,
  output logic [DW-1:0] Byp_Data
`endif
);

  logic [1:0]    pend_v;
  logic [AW-1:0] pend_addr [2];
  logic [DW-1:0] pend_data [2];
  logic          older;      // index of the older buffer when both are valid
  logic          rr_ptr;     // preferred buffer for the next contended grant

  logic [1:0]    in_valid;
  logic [AW-1:0] in_addr [2];
  logic [DW-1:0] in_data [2];
  logic [1:0]    grant;
  logic [1:0]    discard;
  logic [1:0]    ready;
  logic [1:0]    load;
  logic          contended;
  logic          gnt_idx;

  assign in_valid   = {WB1_Valid, WB0_Valid};
  assign in_addr[0] = WB0_Addr;
  assign in_addr[1] = WB1_Addr;
  assign in_data[0] = WB0_Data;
  assign in_data[1] = WB1_Data;

  // Arbitration: a same-address pair collapses onto the younger entry, a
  // genuine contention is resolved by rr_ptr (or fixed WB0 priority).
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    grant     = '0;
    discard   = '0;
    contended = 1'b0;
    if (&pend_v) begin
      if (pend_addr[0] == pend_addr[1]) begin
        grant[~older]  = 1'b1;
        discard[older] = 1'b1;
      end else begin
        contended = 1'b1;
        if (ARB_RR != 0 && rr_ptr) grant[1] = 1'b1;
        else                       grant[0] = 1'b1;
      end
    end else begin
      grant = pend_v;
    end
  end

  assign gnt_idx   = grant[1];
  assign ready     = ~pend_v | grant;
  assign WB0_Ready = ready[0];
  assign WB1_Ready = ready[1];
  assign load[0]   = in_valid[0] & ready[0] & (in_addr[0] != '0);
  assign load[1]   = in_valid[1] & ready[1] & (in_addr[1] != '0);
  assign Busy      = (|pend_v) | RegWrite;

  // Buffer occupancy, relative age and round-robin pointer.
  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (Reset) begin
      pend_v <= '0;
      older  <= 1'b0;
      rr_ptr <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (load[i])                     pend_v[i] <= 1'b1;
        else if (grant[i] || discard[i]) pend_v[i] <= 1'b0;
      end
      // The most recently loaded entry is the younger one; WB1 wins a tie.
      if (load[1])      older <= 1'b0;
      else if (load[0]) older <= 1'b1;
      // Only a real choice between two buffers moves the pointer, so a lone
      // grant does not steal the other requester's turn.
      if (contended) rr_ptr <= ~gnt_idx;
    end
  end

  // Buffer payload capture.
  always_ff @(posedge Clk) begin
    // NOTE: payload storage is not reset; pend_v alone decides whether an
    // entry is meaningful.
    for (int i = 0; i < 2; i++) begin
      if (load[i]) begin
        pend_addr[i] <= in_addr[i];
        pend_data[i] <= in_data[i];
      end
    end
  end

  // Registered GRF write port; address and data hold when idle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      RegWrite <= 1'b0;
      RD       <= '0;
      WData    <= '0;
    end else begin
      RegWrite <= |grant;
      if (|grant) begin
        RD    <= pend_addr[gnt_idx];
        WData <= pend_data[gnt_idx];
      end
    end
  end

`ifdef GRF_WB_BYPASS_EN
  // Read-stage bypass: youngest buffered value first, then the output register.
  always_comb begin
    Byp_Hit  = 1'b0;
    Byp_Data = '0;
    if (Byp_Addr != '0) begin
      if (pend_v[~older] && pend_addr[~older] == Byp_Addr) begin
        Byp_Hit  = 1'b1;
        Byp_Data = pend_data[~older];
      end else if (pend_v[older] && pend_addr[older] == Byp_Addr) begin
        Byp_Hit  = 1'b1;
        Byp_Data = pend_data[older];
      end else if (RegWrite && RD == Byp_Addr) begin
        Byp_Hit  = 1'b1;
        Byp_Data = WData;
      end
    end
  end
`endif

endmodule
